// File: rtl/streaming_argmax_accumulator.sv
// Streaming argmax accumulator: folds NUM_CHUNKS per-chunk (max, local index) results
// into one group-wide (max, global index) result, presented with a valid/ready handshake.
module streaming_argmax_accumulator #(
    parameter  int WIDTH      = 8,
    parameter  int NUM_CHUNKS = 4,
    localparam int IDX_WIDTH  = 4 + $clog2(NUM_CHUNKS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_max,
    input  logic        [3:0]       in_argmax,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_max,
    output logic [IDX_WIDTH-1:0]    out_argmax
);

    // A single-chunk group still needs a one-bit counter that simply stays at zero.
    localparam int CNT_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [WIDTH-1:0] best_max_q, best_max_d;
    logic [IDX_WIDTH-1:0]    best_idx_q, best_idx_d;
    logic                    accept;

    function automatic logic [IDX_WIDTH-1:0] global_idx(
        input logic [CNT_W-1:0] chunk,
        input logic [3:0]       local_idx
    );
        return (IDX_WIDTH'(chunk) << 4) | IDX_WIDTH'(local_idx);
    endfunction

    function automatic logic beats_best(
        input logic signed [WIDTH-1:0] candidate,
        input logic signed [WIDTH-1:0] incumbent
    );
        // Strictly greater, so an equal value in a later chunk never displaces an earlier one.
        return candidate > incumbent;
    endfunction

    assign in_ready   = (state_q == ACCUM);
    assign out_valid  = (state_q == DONE);
    assign out_max    = best_max_q;
    assign out_argmax = best_idx_q;
    assign accept     = in_valid && (state_q == ACCUM);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        best_max_d = best_max_q;
        best_idx_d = best_idx_q;

        if (clear) begin
            state_d = ACCUM;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (accept) begin
                        if (cnt_q == '0 || beats_best(in_max, best_max_q)) begin
                            best_max_d = in_max;
                            best_idx_d = global_idx(cnt_q, in_argmax);
                        end
                        if (cnt_q == LAST_CNT) begin
                            cnt_d   = '0;
                            state_d = DONE;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = ACCUM;
                    end
                end
                default: begin
                    state_d = ACCUM;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Result registers are cleared on reset so the outputs read zero before the first group.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ACCUM;
            cnt_q      <= '0;
            best_max_q <= '0;
            best_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            best_max_q <= best_max_d;
            best_idx_q <= best_idx_d;
        end
    end

endmodule

// File: tb/tb_streaming_argmax_accumulator.sv
// Bench for streaming_argmax_accumulator: directed and random groups, scoreboard-checked results.
module tb_streaming_argmax_accumulator;

    localparam int NC = 4;

    logic              clk = 1'b0;
    logic              rst, clear, in_valid, out_ready;
    logic signed [7:0] in_max;
    logic        [3:0] in_argmax;
    logic              in_ready, out_valid;
    logic signed [7:0] out_max;
    logic        [5:0] out_argmax;

    logic              clear1, in_valid1, out_ready1;
    logic signed [7:0] in_max1;
    logic        [3:0] in_argmax1;
    logic              in_ready1, out_valid1;
    logic signed [7:0] out_max1;
    logic        [3:0] out_argmax1;

    streaming_argmax_accumulator #(.WIDTH(8), .NUM_CHUNKS(NC)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_max(in_max), .in_argmax(in_argmax),
        .out_valid(out_valid), .out_ready(out_ready), .out_max(out_max), .out_argmax(out_argmax)
    );

    streaming_argmax_accumulator #(.WIDTH(8), .NUM_CHUNKS(1)) dut1 (
        .clk(clk), .rst(rst), .clear(clear1),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_max(in_max1), .in_argmax(in_argmax1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_max(out_max1), .out_argmax(out_argmax1)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int eq_max[$];
    int eq_idx[$];
    int gm[$];
    int ga[$];
    int last_max, last_idx;
    bit pending = 1'b0;

    task automatic chk(input string name, input logic signed [31:0] act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: once a group is complete, find the largest value, then the first chunk holding it.
    task automatic model_accept(input int m, input int a);
        int mx;
        int k;
        gm.push_back(m);
        ga.push_back(a);
        if (gm.size() == NC) begin
            mx = gm[0];
            foreach (gm[i]) if (gm[i] > mx) mx = gm[i];
            k = 0;
            while (gm[k] != mx) k++;
            last_max = mx;
            last_idx = k * 16 + ga[k];
            eq_max.push_back(last_max);
            eq_idx.push_back(last_idx);
            gm.delete();
            ga.delete();
            pending = 1'b1;
        end
    endtask

    task automatic model_abort();
        gm.delete();
        ga.delete();
        if (pending) begin
            void'(eq_max.pop_back());
            void'(eq_idx.pop_back());
            pending = 1'b0;
        end
    endtask

    // All driver tasks enter and leave 1 time unit after a rising edge.
    task automatic beat(input int m, input int a);
        chk("in_ready_accum", in_ready, 1);
        chk("out_valid_accum", out_valid, 0);
        in_valid  = 1'b1;
        in_max    = 8'(m);
        in_argmax = 4'(a);
        @(posedge clk); #1;
        in_valid = 1'b0;
        model_accept(m, a);
        if (pending) begin
            chk("out_valid_latency", out_valid, 1);
            chk("in_ready_done", in_ready, 0);
        end
    endtask

    task automatic collect(input int hold, input bit junk);
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            in_valid  = junk;
            in_max    = 8'sd127;
            in_argmax = 4'd15;
            @(posedge clk); #1;
            chk("hold_out_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_out_max", out_max, last_max);
            chk("hold_out_argmax", out_argmax, last_idx);
        end
        out_ready = 1'b1;
        in_valid  = junk;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        pending   = 1'b0;
        chk("post_handshake_out_valid", out_valid, 0);
        chk("post_handshake_in_ready", in_ready, 1);
    endtask

    task automatic do_clear(input bit with_beat);
        clear     = 1'b1;
        in_valid  = with_beat;
        in_max    = 8'sd127;
        in_argmax = 4'($urandom_range(0, 15));
        @(posedge clk); #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        model_abort();
        chk("clear_out_valid", out_valid, 0);
        chk("clear_in_ready", in_ready, 1);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b1;
        in_max   = 8'sd127;
        @(posedge clk); #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        model_abort();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_max", out_max, 0);
        chk("rst_out_argmax", out_argmax, 0);
    endtask

    task automatic rand_beat();
        int m;
        if ($urandom_range(0, 1) == 1) m = int'($urandom_range(0, 4)) - 2;
        else m = int'($urandom_range(0, 255)) - 128;
        beat(m, int'($urandom_range(0, 15)));
    endtask

    task automatic single_beat(input int m, input int a);
        in_valid1  = 1'b1;
        in_max1    = 8'(m);
        in_argmax1 = 4'(a);
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        chk("n1_out_valid", out_valid1, 1);
        chk("n1_in_ready", in_ready1, 0);
        chk("n1_out_max", out_max1, m);
        chk("n1_out_argmax", out_argmax1, a);
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        out_ready1 = 1'b0;
        chk("n1_release_out_valid", out_valid1, 0);
        chk("n1_release_in_ready", in_ready1, 1);
    endtask

    // Monitor: every completed output handshake is matched against the oldest expected result.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (eq_max.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_result: got max %0d idx %0d, expected none", out_max, out_argmax);
            end else begin
                chk("out_max", out_max, eq_max.pop_front());
                chk("out_argmax", out_argmax, eq_idx.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_max = '0; in_argmax = '0;
        clear1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0; in_max1 = '0; in_argmax1 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_max", out_max, 0);
        chk("reset_out_argmax", out_argmax, 0);
        chk("reset_n1_out_valid", out_valid1, 0);

        beat(10, 3); beat(-5, 0); beat(27, 15); beat(27, 2);
        chk("tie_keeps_earlier", last_idx, 47);
        collect(0, 1'b0);

        beat(-128, 0); beat(-100, 7); beat(-128, 1); beat(-101, 4);
        collect(5, 1'b1);

        beat(50, 1); beat(60, 2);
        do_reset();
        beat(1, 0); beat(2, 0); beat(3, 0); beat(4, 5);
        collect(1, 1'b0);

        beat(9, 1);
        do_clear(1'b1);
        beat(5, 2); beat(6, 3); beat(7, 4); beat(8, 5);
        collect(0, 1'b0);
        beat(100, 1); beat(1, 1); beat(2, 2); beat(3, 3);
        do_clear(1'b0);
        beat(-1, 6); beat(-2, 7); beat(-1, 8); beat(-3, 9);
        collect(2, 1'b0);

        for (int g = 0; g < 60; g++) begin
            while (!pending) begin
                case ($urandom_range(0, 19))
                    0:       do_clear($urandom_range(0, 1) == 1);
                    1:       if (gm.size() > 0) do_reset(); else rand_beat();
                    default: rand_beat();
                endcase
            end
            if ($urandom_range(0, 9) == 0) do_clear(1'b0);
            else collect(int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
        end

        single_beat(-3, 9);
        for (int i = 0; i < 6; i++)
            single_beat(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 15)));

        repeat (2) @(posedge clk);
        #1;
        chk("results_outstanding", eq_max.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/streaming_argmax_accumulator.md
STREAMING_ARGMAX_ACCUMULATOR -- requirements
Module: streaming_argmax_accumulator

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bit width of the signed max value.
REQ-002 SHALL have parameter NUM_CHUNKS, default 4: number of 16-input argmax results per group; legal values are 1 and above.
REQ-003 SHALL derive localparam IDX_WIDTH = 4 + $clog2(NUM_CHUNKS), which equals 4 when NUM_CHUNKS = 1.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 clear  input  1  synchronous abort of the current group; lower priority than rst.
REQ-008 in_valid  input  1  chunk result is valid.
REQ-009 in_ready  output  1  block accepts a chunk result this cycle.
REQ-010 in_max  input  WIDTH signed  max of the 16-element chunk from the upstream argmax stage.
REQ-011 in_argmax  input  4  local index, 0..15, of in_max within its chunk.
REQ-012 out_valid  output  1  group result is valid.
REQ-013 out_ready  input  1  consumer accepts the group result.
REQ-014 out_max  output  WIDTH signed  global max over the group.
REQ-015 out_argmax  output  IDX_WIDTH  global index of out_max, equal to chunk_number*16 + local index.

Function
REQ-016 SHALL implement two states: ACCUM and DONE.
REQ-017 In ACCUM, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-018 In DONE, in_ready SHALL be 0 and out_valid SHALL be 1.
REQ-019 A beat SHALL be accepted only when in_valid and in_ready are both 1 at a rising edge; in_valid while in DONE SHALL be ignored and SHALL NOT be stored.
REQ-020 SHALL keep chunk counter cnt, range 0..NUM_CHUNKS-1, which increments on each accepted beat.
REQ-021 On the beat accepted with cnt == 0, the block SHALL load best_max = in_max and best_idx = {0, in_argmax} unconditionally.
REQ-022 On later beats, the block SHALL replace best_max and best_idx only if in_max > best_max under signed comparison; the replacement index is cnt*16 + in_argmax.
REQ-023 On a tie, the earlier chunk SHALL win.
REQ-024 On the beat accepted with cnt == NUM_CHUNKS-1, the block SHALL update best_max and best_idx, reset cnt to 0 and enter DONE.
REQ-025 out_valid SHALL assert in the cycle after the last beat is accepted, giving a latency of 1 cycle.
REQ-026 out_max SHALL be driven directly from register best_max and out_argmax from register best_idx; both SHALL stay stable while out_valid = 1 and out_ready = 0.
REQ-027 In DONE with out_ready = 1, the block SHALL return to ACCUM on the next edge.
REQ-028 in_ready SHALL NOT assert in the same cycle as the DONE handshake; minimum group period is NUM_CHUNKS + 1 cycles.
REQ-029 When NUM_CHUNKS = 1, every accepted beat SHALL go directly to DONE, with out_max = in_max and out_argmax = in_argmax.
REQ-030 Index arithmetic SHALL be unsigned in IDX_WIDTH bits and SHALL never overflow, because the maximum value is NUM_CHUNKS*16 - 1.
REQ-031 clear = 1 SHALL, on the next edge, set state to ACCUM, cnt to 0 and out_valid to 0, and SHALL discard any beat presented in that cycle.
REQ-032 clear SHALL behave the same in both states, so that a pending DONE result is dropped.
REQ-033 The datapath SHALL be purely sequential; there SHALL be no combinational path from in_* to out_*.

Reset
REQ-034 rst = 1 SHALL, on the next edge, set state to ACCUM, cnt to 0, out_valid to 0, in_ready to 1, out_max to 0 and out_argmax to 0.
REQ-035 rst SHALL take priority over clear and over all handshakes.
REQ-036 A reset asserted mid-group SHALL discard all partial results; the first beat after reset SHALL be treated as chunk 0.

Verification
REQ-037 WIDTH = 8, NUM_CHUNKS = 4; beats (max, idx) = (10,3), (-5,0), (27,15), (27,2) -> one cycle after the last beat: out_valid = 1, out_max = 27, out_argmax = 47 (tie with chunk 3 keeps chunk 2).
REQ-038 Beats (-128,0), (-100,7), (-128,1), (-101,4) -> out_max = -100, out_argmax = 23 (confirms signed compare).
REQ-039 After DONE, hold out_ready = 0 for 5 cycles with in_valid = 1 and in_max = 127 -> in_ready = 0 and outputs unchanged throughout; then out_ready = 1 -> next cycle out_valid = 0 and in_ready = 1, and the in_max = 127 beats were never absorbed.
REQ-040 Accept 2 beats (50,1), (60,2), then pulse rst -> out_valid = 0 and out_argmax = 0; then beats (1,0), (2,0), (3,0), (4,5) -> out_max = 4, out_argmax = 53.
REQ-041 Mid-group clear coincident with in_valid = 1 -> that beat is dropped and the next beat becomes chunk 0; a clear in DONE drops the pending result.
REQ-042 NUM_CHUNKS = 1 instance: beat (-3,9) -> next cycle out_valid = 1, out_max = -3, out_argmax = 9.
